switch_mem_regfile: RTL
=======================

SWITCH_MEM_REGFILE -- requirements
Module: switch_mem_regfile

Interface
REQ-001 SHALL have parameter INIT_BASE, default 8'h00: reset value of port address register i is INIT_BASE+i (mod 256).
REQ-002 SHALL have parameter DUP_CHECK, default 1: when 0, dup_err is tied to 0.
REQ-003 SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-004 clock  in  1  sole clock; all state changes on the posedge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 mem_en  in  1  transaction valid; sampled at the posedge.
REQ-007 mem_rd_wr  in  1  1 = write, 0 = read.
REQ-008 mem_add  in  2  register index 0..3.
REQ-009 mem_data  in  8  write data.
REQ-010 cfg_busy  in  1  switch is forwarding packets, so configuration commits are deferred.
REQ-011 err_clr  in  1  clears cfg_ovf_err.
REQ-012 rd_data  out  8  read response data.
REQ-013 rd_valid  out  1  read response strobe, one cycle wide.
REQ-014 port_addr  out  32  committed registers; register i is at bits [8i+7:8i].
REQ-015 cfg_written  out  4  bit i = register i committed since reset.
REQ-016 cfg_pending  out  1  a deferred write is held.
REQ-017 cfg_ovf_err  out  1  sticky flag: a write was dropped.
REQ-018 dup_err  out  1  two written registers hold equal values.

Function
REQ-019 A transaction SHALL exist only at a posedge with mem_en=1; mem_rd_wr, mem_add and mem_data SHALL be ignored when mem_en=0.
REQ-020 Write with cfg_busy=0 and cfg_pending=0: the addressed register SHALL update at that edge and be visible on port_addr after it; cfg_written[mem_add] SHALL set.
REQ-021 Write with cfg_busy=1 and cfg_pending=0: address and data SHALL be captured in the single pending slot and cfg_pending SHALL go to 1; port_addr SHALL be unchanged.
REQ-022 Pending commit: at the first edge with cfg_busy=0, the slot SHALL commit to its register, its cfg_written bit SHALL set, and cfg_pending SHALL clear at that same edge.
REQ-023 Write with cfg_pending=1 and cfg_busy=1: the write SHALL be dropped and cfg_ovf_err SHALL set; the slot contents SHALL be unchanged.
REQ-024 Write with cfg_pending=1 and cfg_busy=0 at the same edge: both the slot and the new write SHALL commit at that edge. If both target the same address, the new write's data SHALL win.
REQ-025 Read: rd_data SHALL equal the committed register value as held before the sampling edge, and rd_valid SHALL be 1 for exactly the following cycle (latency 1). Pending data SHALL never be returned.
REQ-026 Reads SHALL be serviced regardless of cfg_busy or cfg_pending; back-to-back reads SHALL give rd_valid high on consecutive cycles.
REQ-027 rd_data SHALL hold its last value when rd_valid=0.
REQ-028 dup_err SHALL be registered and SHALL be 1 in the cycle after any edge at which two registers i≠j have both cfg_written bits set and equal values. It SHALL be a level flag, recomputed every cycle.
REQ-029 err_clr=1 SHALL clear cfg_ovf_err at the edge; a dropped write at the same edge SHALL win, leaving the flag set.
REQ-030 cfg_written bits SHALL clear only on reset.

Reset
REQ-031 With reset_n=0, outputs SHALL take these values asynchronously:
- port_addr[i] = INIT_BASE+i
- cfg_written = 0
- cfg_pending = 0
- cfg_ovf_err = 0
- dup_err = 0
- rd_valid = 0
- rd_data = 0
REQ-032 Reset while cfg_pending=1 SHALL discard the slot with no commit. A read in flight SHALL produce no rd_valid.
REQ-033 The first transaction SHALL be accepted at the first posedge after reset_n rises.

Verification
REQ-034 Reset, then write addr1=8'h55 with cfg_busy=0 -> port_addr[15:8]=8'h55 after the edge, cfg_written=4'b0010; a read of addr1 -> rd_valid one cycle later with rd_data=8'h55.
REQ-035 cfg_busy=1, write addr2=8'hA0 -> cfg_pending=1 and port_addr[23:16] still 8'h02 (INIT_BASE=0); a read of addr2 returns 8'h02; drop cfg_busy -> 8'hA0 commits and cfg_pending=0 at the same edge.
REQ-036 cfg_busy=1 with a pending write, then a second write -> cfg_ovf_err=1 and the original slot commits later; err_clr pulse -> cfg_ovf_err=0; err_clr coincident with a new drop -> cfg_ovf_err stays 1.
REQ-037 Pending addr0=8'h11, then cfg_busy falls in the same cycle as a write addr0=8'h22 -> port_addr[7:0]=8'h22. Repeat with a new write to addr3=8'h33 -> both 8'h11 and 8'h33 commit.
REQ-038 Write addr0=8'h07 and addr3=8'h07 -> dup_err=1 the cycle after the second commit; rewrite addr3=8'h08 -> dup_err=0 one cycle after that commit.
REQ-039 Assert reset_n=0 mid-pending and during an outstanding read -> all outputs at reset values immediately, with no later commit and no rd_valid.

Source files
------------

// File: rtl/switch_mem_regfile_if.sv
// Transaction bus of the port-address register file.
// The master issues reads and writes and receives the read response;
// the slave is the register file itself.
//   mem_en     : transaction valid, sampled at the clock posedge
//   mem_rd_wr  : 1 = write, 0 = read
//   mem_add    : register index 0..3
//   mem_data   : write data
//   rd_data    : read response data, held between responses
//   rd_valid   : one-cycle read response strobe
interface switch_mem_regfile_if;
    logic       mem_en;
    logic       mem_rd_wr;
    logic [1:0] mem_add;
    logic [7:0] mem_data;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport master (
        output mem_en,
        output mem_rd_wr,
        output mem_add,
        output mem_data,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  mem_en,
        input  mem_rd_wr,
        input  mem_add,
        input  mem_data,
        output rd_data,
        output rd_valid
    );
endinterface

// File: rtl/switch_mem_regfile.sv
// Four 8-bit port address registers for a packet switch.
// While the switch is forwarding (cfg_busy=1), a write is parked in a
// single pending slot and committed at the first edge with cfg_busy=0.
// A second write that arrives while the slot is occupied and the switch
// is still busy is dropped and flagged in a sticky overflow bit.
// Ports:
//   clock, reset_n : sole clock, asynchronous active-low reset
//   bus            : transaction bus (slave side)
//   cfg_busy       : defer configuration commits
//   err_clr        : clear cfg_ovf_err
//   port_addr      : committed registers, register i at [8i+7:8i]
//   cfg_written    : bit i set once register i has been committed
//   cfg_pending    : a deferred write is held in the slot
//   cfg_ovf_err    : sticky, a write was dropped
//   dup_err        : two written registers hold equal values
module switch_mem_regfile #(
    parameter logic [7:0] INIT_BASE = 8'h00,
    parameter bit         DUP_CHECK = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    switch_mem_regfile_if.slave  bus,
    input  logic                 cfg_busy,
    input  logic                 err_clr,
    output logic [31:0]          port_addr,
    output logic [3:0]           cfg_written,
    output logic                 cfg_pending,
    output logic                 cfg_ovf_err,
    output logic                 dup_err
);

    logic [7:0] regs      [4];
    logic [7:0] regs_nxt  [4];
    logic [3:0] written_nxt;
    logic [1:0] pend_add;
    logic [7:0] pend_data;
    logic       wr_req;
    logic       rd_req;
    logic       slot_commit;
    logic       slot_capture;
    logic       wr_drop;
    logic       dup_now;

    assign wr_req       = bus.mem_en &  bus.mem_rd_wr;
    assign rd_req       = bus.mem_en & ~bus.mem_rd_wr;
    assign slot_commit  = cfg_pending & ~cfg_busy;
    assign slot_capture = wr_req & cfg_busy & ~cfg_pending;
    assign wr_drop      = wr_req & cfg_busy &  cfg_pending;

    // The slot is applied first so that a direct write to the same
    // register at the same edge overrides it.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            regs_nxt[i] = regs[i];
        end
        written_nxt = cfg_written;
        if (slot_commit) begin
            regs_nxt[pend_add]    = pend_data;
            written_nxt[pend_add] = 1'b1;
        end
        if (wr_req && !cfg_busy) begin
            regs_nxt[bus.mem_add]    = bus.mem_data;
            written_nxt[bus.mem_add] = 1'b1;
        end
    end

    // Evaluated on the registers as held before the edge, giving one
    // cycle of latency from a commit to the flag.
    always_comb begin
        dup_now = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (cfg_written[i] && cfg_written[j] && (regs[i] == regs[j])) begin
                    dup_now = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= INIT_BASE + 8'(i);
            end
            cfg_written  <= 4'b0000;
            cfg_pending  <= 1'b0;
            pend_add     <= 2'd0;
            pend_data    <= 8'h00;
            cfg_ovf_err  <= 1'b0;
            dup_err      <= 1'b0;
            bus.rd_data  <= 8'h00;
            bus.rd_valid <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= regs_nxt[i];
            end
            cfg_written <= written_nxt;

            if (slot_capture) begin
                cfg_pending <= 1'b1;
                pend_add    <= bus.mem_add;
                pend_data   <= bus.mem_data;
            end else if (slot_commit) begin
                cfg_pending <= 1'b0;
            end

            // A drop at the same edge as err_clr keeps the flag set.
            if (wr_drop) begin
                cfg_ovf_err <= 1'b1;
            end else if (err_clr) begin
                cfg_ovf_err <= 1'b0;
            end

            dup_err <= DUP_CHECK && dup_now;

            bus.rd_valid <= rd_req;
            if (rd_req) begin
                bus.rd_data <= regs[bus.mem_add];
            end
        end
    end

    assign port_addr = {regs[3], regs[2], regs[1], regs[0]};

endmodule
